request_unit: RTL and testbench
===============================

// Module: request_unit
// PURPOSE
//  Memory request unit between the program counter and the cache/memory
//  interface. Drives instruction fetch at the current PC and holds data
//  requests for load/store until serviced. Produces pcen for the program
//  counter: the PC advances only after the full instruction has completed.
//  Tracks halt and counts stall cycles for performance debug.
// PARAMETERS
//  WORD_W  32  width of PC and address words
//  CNT_W   16  width of saturating stall-cycle counter
// PORTS
//  CLK        in   1       system clock; all state updates on rising edge
//  RST        in   1       synchronous reset, active-high
//  cpc        in   WORD_W  current PC from program counter
//  ihit       in   1       instruction memory returned data this cycle
//  dhit       in   1       data memory completed access this cycle
//  dren_dec   in   1       decoded instruction is a load
//  dwen_dec   in   1       decoded instruction is a store
//  halt_dec   in   1       decoded instruction is HALT
//  imemaddr   out  WORD_W  instruction address (= cpc, combinational)
//  imemREN    out  1       instruction read enable
//  dmemREN    out  1       data read enable (registered)
//  dmemWEN    out  1       data write enable (registered)
//  pcen       out  1       PC advance strobe to program counter
//  halt       out  1       sticky halt flag
//  stall_cnt  out  CNT_W   cycles spent waiting on ihit/dhit
// BEHAVIOUR
//  Interface: one clock (CLK); reset (RST) synchronous, active-high.
//  Reset values: state=FETCH, dmemREN=0, dmemWEN=0, halt=0,
//    stall_cnt=0; while RST high: imemREN=0 and pcen=0.
//  States: FETCH, DATA, HALTED.
//  FETCH: imemREN=1, dmem enables 0.
//    ihit & halt_dec            -> HALTED, pcen=0 (halt beats mem ops)
//    ihit & (dren_dec|dwen_dec) -> DATA; next cycle dmemWEN=dwen_dec,
//      dmemREN=dren_dec & ~dwen_dec (store wins if both); pcen=0
//    ihit otherwise             -> stay FETCH, pcen=1 same cycle
//    no ihit                    -> stay, pcen=0, stall_cnt++
//  DATA: imemREN=0; dmem enables held stable until dhit.
//    dhit -> FETCH; pcen=1 same cycle; dmem enables cleared next cycle.
//    no dhit -> stay; stall_cnt++. ihit and decode inputs ignored.
//  HALTED: imemREN=0, dmem enables 0, pcen=0, halt=1; exits only on RST.
//  pcen is combinational; at most one pcen pulse per instruction.
//  stall_cnt saturates at 2**CNT_W-1; never wraps.
//  RST asserted mid-access (DATA or HALTED): next cycle FETCH with all
//    registers at reset values; in-flight data request abandoned.
// TESTING
//  1 Reset, then ALU instr with ihit on 1st FETCH cycle -> pcen=1 that
//    cycle, dmemREN/dmemWEN stay 0, stall_cnt=0.
//  2 Load: ihit+dren_dec, dhit 3 cycles into DATA -> dmemREN=1 for 3 cycles,
//    imemREN=0 in DATA, single pcen at dhit, stall_cnt=2.
//  3 dren_dec=dwen_dec=1 with ihit -> dmemWEN=1, dmemREN=0.
//  4 halt_dec+dwen_dec with ihit -> HALTED, halt=1, dmemWEN never set;
//    holds 20 cycles; RST -> halt=0, FETCH.
//  5 CNT_W=4, withhold ihit 20 cycles -> stall_cnt saturates at 15.
//  6 RST during DATA with dmemREN=1 -> next cycle dmemREN=0, FETCH,
//    imemREN=1 after RST drops.

Source files
------------

// File: rtl/request_unit.sv
// Memory request unit: drives instruction fetch at the current PC, holds load/store
// requests until the data side completes, and strobes pcen once per finished instruction.
module request_unit #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] cpc,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dren_dec,
    input  logic              dwen_dec,
    input  logic              halt_dec,
    output logic [WORD_W-1:0] imemaddr,
    output logic              imemREN,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic              pcen,
    output logic              halt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_next;
    logic   stall_inc;
    logic   mem_issue;

    assign imemaddr = cpc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= FETCH;
            dmemREN   <= 1'b0;
            dmemWEN   <= 1'b0;
            halt      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            // Enables are latched on issue and held until the access leaves DATA
            if (mem_issue) begin
                dmemWEN <= dwen_dec;
                dmemREN <= dren_dec & ~dwen_dec;
            end else if (state_next != DATA) begin
                dmemWEN <= 1'b0;
                dmemREN <= 1'b0;
            end
            if (state_next == HALTED) begin
                halt <= 1'b1;
            end
            if (stall_inc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        imemREN    = 1'b0;
        pcen       = 1'b0;
        stall_inc  = 1'b0;
        mem_issue  = 1'b0;
        case (state)
            FETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    // Halt takes priority over any memory operation in the same instruction
                    if (halt_dec) begin
                        state_next = HALTED;
                    end else if (dren_dec || dwen_dec) begin
                        state_next = DATA;
                        mem_issue  = 1'b1;
                    end else begin
                        pcen = 1'b1;
                    end
                end else begin
                    stall_inc = 1'b1;
                end
            end
            DATA: begin
                if (dhit) begin
                    state_next = FETCH;
                    pcen       = 1'b1;
                end else begin
                    stall_inc = 1'b1;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
        if (RST) begin
            imemREN = 1'b0;
            pcen    = 1'b0;
        end
    end

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic checked against an instruction-level reference model.
module tb_request_unit;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic              CLK;
    logic              RST;
    logic [WORD_W-1:0] cpc;
    logic              ihit;
    logic              dhit;
    logic              dren_dec;
    logic              dwen_dec;
    logic              halt_dec;
    logic [WORD_W-1:0] imemaddr;
    logic              imemREN;
    logic              dmemREN;
    logic              dmemWEN;
    logic              pcen;
    logic              halt;
    logic [CNT_W-1:0]  stall_cnt;

    int passCount;
    int checkCount;

    request_unit #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cpc       (cpc),
        .ihit      (ihit),
        .dhit      (dhit),
        .dren_dec  (dren_dec),
        .dwen_dec  (dwen_dec),
        .halt_dec  (halt_dec),
        .imemaddr  (imemaddr),
        .imemREN   (imemREN),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .pcen      (pcen),
        .halt      (halt),
        .stall_cnt (stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // in  = {rst, ihit, dhit, dren, dwen, halt_dec}
    // out = {imemREN, pcen, dmemREN, dmemWEN, halt}
    typedef struct {
        logic [5:0] in;
        logic [4:0] out;
        int         stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [5:0] in, logic [4:0] out, int stall);
        vec_t v;
        v.in    = in;
        v.out   = out;
        v.stall = stall;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later
    task automatic applyStimulus(input logic [5:0] in);
        @(negedge CLK);
        {RST, ihit, dhit, dren_dec, dwen_dec, halt_dec} = in;
        cpc = $urandom;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] expOut, input int expStall);
        logic [4:0] got;
        got = {imemREN, pcen, dmemREN, dmemWEN, halt};
        checkCount++;
        if (got === expOut && stall_cnt === CNT_W'(expStall) && imemaddr === cpc) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got {imemREN,pcen,dREN,dWEN,halt}=%b stall=%0d addr=%h, want %b stall=%0d addr=%h",
                     name, got, stall_cnt, imemaddr, expOut, expStall, cpc);
        end
    endtask

    // Reference model: tracks the instruction in flight, not the controller's states
    bit modelHalted;
    bit modelPending;
    bit modelWrite;
    int modelStalls;

    initial begin
        logic [5:0] in;
        logic [4:0] expOut;
        bit         expImem;
        bit         expPc;
        int         expStall;

        passCount  = 0;
        checkCount = 0;
        {RST, ihit, dhit, dren_dec, dwen_dec, halt_dec} = 6'b100000;
        cpc = '0;
        repeat (2) @(negedge CLK);

        vecs.push_back(mk(6'b100000, 5'b00000, 0));
        vecs.push_back(mk(6'b010000, 5'b11000, 0));
        vecs.push_back(mk(6'b010100, 5'b10000, 0));
        vecs.push_back(mk(6'b000000, 5'b00100, 0));
        vecs.push_back(mk(6'b000000, 5'b00100, 1));
        vecs.push_back(mk(6'b001000, 5'b01100, 2));
        vecs.push_back(mk(6'b000100, 5'b10000, 2));
        vecs.push_back(mk(6'b010110, 5'b10000, 3));
        vecs.push_back(mk(6'b011100, 5'b01010, 3));
        vecs.push_back(mk(6'b010000, 5'b11000, 3));
        vecs.push_back(mk(6'b010100, 5'b10000, 3));
        vecs.push_back(mk(6'b000000, 5'b00100, 3));
        vecs.push_back(mk(6'b100000, 5'b00100, 4));
        vecs.push_back(mk(6'b000000, 5'b10000, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].in);
            checkOutput($sformatf("vec%0d", i), vecs[i].out, vecs[i].stall);
        end

        // Halt combined with a store: no write is ever issued, halt is sticky until reset
        applyStimulus(6'b010011);
        checkOutput("halt_issue", 5'b10000, 1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(6'b011110);
            checkOutput($sformatf("halt_hold%0d", i), 5'b00001, 1);
        end
        applyStimulus(6'b100000);
        checkOutput("halt_rst", 5'b00001, 1);
        applyStimulus(6'b010000);
        checkOutput("halt_exit", 5'b11000, 0);

        // Stall counter saturation with ihit withheld
        applyStimulus(6'b100000);
        checkOutput("sat_rst", 5'b00000, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(6'b000000);
            checkOutput($sformatf("sat%0d", i), 5'b10000, (i > SAT) ? SAT : i);
        end

        // Randomized traffic against the reference model
        applyStimulus(6'b100000);
        checkOutput("rand_rst", 5'b00000, SAT);
        modelHalted  = 0;
        modelPending = 0;
        modelWrite   = 0;
        modelStalls  = 0;
        for (int c = 0; c < 400; c++) begin
            in[5] = ($urandom_range(0, 19) == 0);
            in[4] = ($urandom_range(0, 1) == 1);
            in[3] = ($urandom_range(0, 9) < 4);
            in[2] = ($urandom_range(0, 3) == 0);
            in[1] = ($urandom_range(0, 3) == 0);
            in[0] = ($urandom_range(0, 15) == 0);
            applyStimulus(in);

            expImem  = !in[5] && !modelHalted && !modelPending;
            expPc    = !in[5] && ((expImem && in[4] && !in[0] && !in[2] && !in[1]) ||
                                  (modelPending && in[3]));
            expOut   = {expImem, expPc, modelPending && !modelWrite, modelPending && modelWrite, modelHalted};
            expStall = (modelStalls > SAT) ? SAT : modelStalls;
            checkOutput($sformatf("rand%0d", c), expOut, expStall);

            if (in[5]) begin
                modelHalted  = 0;
                modelPending = 0;
                modelWrite   = 0;
                modelStalls  = 0;
            end else if (modelHalted) begin
                modelHalted = 1;
            end else if (modelPending) begin
                if (in[3]) modelPending = 0;
                else       modelStalls++;
            end else if (in[4]) begin
                if (in[0]) begin
                    modelHalted = 1;
                end else if (in[2] || in[1]) begin
                    modelPending = 1;
                    modelWrite   = in[1];
                end
            end else begin
                modelStalls++;
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
